controlador_es: RTL and testbench



---
 rtl/controlador_es_pkg.sv | 17 +
 rtl/controlador_es_debounce_botao.sv | 48 ++++
 rtl/controlador_es.sv | 96 +++++++++
 tb/tb_controlador_es.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_es_pkg.sv
// Shared types and constants for the IN/OUT responder of the single-cycle CPU.
// Benches pull the opcode values from here to drive decoder-like stimulus.
package controlador_es_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ESPERA_IN = 2'd1,
    LIBERA    = 2'd2
  } estado_t;

  localparam int DATA_WIDTH_PADRAO = 32;
  localparam int SW_WIDTH_PADRAO   = 16;

  localparam logic [4:0] OPCODE_IN  = 5'b00010;
  localparam logic [4:0] OPCODE_OUT = 5'b00011;

endpackage

// File: rtl/controlador_es_debounce_botao.sv
// Pushbutton conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module debounce_botao
  import controlador_es_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic nivel,
  output logic evtBotao
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sinc1;
  logic          sinc2;
  logic          nivel_ant;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sinc1     <= 1'b0;
      sinc2     <= 1'b0;
      nivel     <= 1'b0;
      nivel_ant <= 1'b0;
      cnt       <= '0;
    end else begin
      sinc1     <= botao;
      sinc2     <= sinc1;
      nivel_ant <= nivel;
      // any sample agreeing with the current level restarts the stability run
      if (sinc2 == nivel) begin
        cnt <= '0;
      end else if (cnt == CNT_FIM) begin
        nivel <= sinc2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evtBotao = nivel & ~nivel_ant;

endmodule

// File: rtl/controlador_es.sv
// IN/OUT responder: stalls the CPU on IN until a debounced button press, then
// hands over the switch word; latches the ALU result into the display on OUT.
module controlador_es
  import controlador_es_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = SW_WIDTH_PADRAO,
  parameter int DATA_WIDTH      = DATA_WIDTH_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lerIn,
  input  logic                  escreverOut,
  input  logic [DATA_WIDTH-1:0] dadoOut,
  input  logic [SW_WIDTH-1:0]   chaves,
  input  logic                  botao,
  output logic                  pausa,
  output logic [DATA_WIDTH-1:0] dadoIn,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  outValido
);

  estado_t estado;
  estado_t prox_estado;
  logic    evt_botao;
  logic    nivel_botao;
  logic    captura;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .botao    (botao),
    .nivel    (nivel_botao),
    .evtBotao (evt_botao)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    pausa       = 1'b0;
    captura     = 1'b0;
    case (estado)
      OCIOSO: begin
        // stall already in the first IN cycle so the PC never slips past it
        pausa = lerIn;
        if (lerIn) begin
          prox_estado = ESPERA_IN;
        end
      end
      ESPERA_IN: begin
        pausa = 1'b1;
        if (evt_botao && nivel_botao) begin
          captura     = 1'b1;
          prox_estado = LIBERA;
        end
      end
      LIBERA: begin
        prox_estado = OCIOSO;
      end
      default: begin
        prox_estado = OCIOSO;
      end
    endcase
    if (!rst_n) begin
      pausa = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dadoIn    <= '0;
      display   <= '0;
      outValido <= 1'b0;
    end else begin
      if (captura) begin
        dadoIn <= DATA_WIDTH'(chaves);
      end
      // a stalled cycle must not commit an OUT
      outValido <= 1'b0;
      if (escreverOut && !pausa) begin
        display   <= dadoOut;
        outValido <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controlador_es.sv
// Self-checking bench for controlador_es with a short debounce window; a
// behavioural model tracks expected outputs under directed and random stimulus.
module tb_controlador_es;
  import controlador_es_pkg::*;

  localparam int D  = 4;
  localparam int SW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lerIn;
  logic          escreverOut;
  logic [DW-1:0] dadoOut;
  logic [SW-1:0] chaves;
  logic          botao;
  logic          pausa;
  logic [DW-1:0] dadoIn;
  logic [DW-1:0] display;
  logic          outValido;

  int ncomp = 0;
  int nerr  = 0;

  controlador_es #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH(SW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lerIn       (lerIn),
    .escreverOut (escreverOut),
    .dadoOut     (dadoOut),
    .chaves      (chaves),
    .botao       (botao),
    .pausa       (pausa),
    .dadoIn      (dadoIn),
    .display     (display),
    .outValido   (outValido)
  );

  always #5 clk = ~clk;

  // Behavioural model: waiting/releasing flags, raw button history per edge.
  bit            m_esp, m_lib, m_nivel, m_evt, m_ov;
  logic [DW-1:0] m_dadoIn, m_display;
  logic          hist[$];

  function automatic logic exp_pausa();
    return rst_n && (m_esp || (!m_lib && lerIn));
  endfunction

  task automatic tick();
    bit p, e, all_diff;
    int n;
    logic v;
    p = exp_pausa();
    e = m_evt;
    if (!rst_n) begin
      m_esp = 0; m_lib = 0; m_nivel = 0; m_evt = 0; m_ov = 0;
      m_dadoIn = '0; m_display = '0;
      hist.delete();
    end else begin
      if (m_esp) begin
        if (e) begin
          m_dadoIn = DW'(chaves);
          m_esp = 0;
          m_lib = 1;
        end
      end else if (m_lib) begin
        m_lib = 0;
      end else if (lerIn) begin
        m_esp = 1;
      end
      m_ov = escreverOut && !p;
      if (m_ov) m_display = dadoOut;
      // level flips once the D samples seen through the 2-edge delay all disagree
      hist.push_back(botao);
      if (hist.size() > 16) void'(hist.pop_front());
      n = hist.size();
      all_diff = 1;
      for (int i = 0; i < D; i++) begin
        v = (n - 3 - i >= 0) ? hist[n-3-i] : 1'b0;
        if (v == m_nivel) all_diff = 0;
      end
      m_evt = 0;
      if (all_diff) begin
        m_nivel = !m_nivel;
        m_evt = m_nivel;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; botao = 1; lerIn = 1; escreverOut = 1;
    dadoOut = $urandom; chaves = SW'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      ncomp++;
      if (pausa !== 1'b0 || dadoIn !== '0 || display !== '0 || outValido !== 1'b0) begin
        nerr++;
        $display("FAIL reset_outputs: pausa=%b dadoIn=%h display=%h outValido=%b, required all 0",
                 pausa, dadoIn, display, outValido);
      end
    end
    rst_n = 1; lerIn = 0; escreverOut = 0;
    for (int i = 0; i < 12; i++) tick();
    // button held since reset: the IN that follows must not see an event
    lerIn = 1; chaves = 16'h1234;
    for (int i = 0; i < 15; i++) begin
      tick();
      ncomp++;
      if (pausa !== 1'b1 || dadoIn !== 32'h0) begin
        nerr++;
        $display("FAIL reset_held_button: pausa=%b dadoIn=%h, required pausa=1 dadoIn=0", pausa, dadoIn);
      end
    end
    botao = 0;
    for (int i = 0; i < 6; i++) tick();
    botao = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_lib) lerIn = 0;
      ncomp++;
      if (pausa !== exp_pausa() || dadoIn !== m_dadoIn) begin
        nerr++;
        $display("FAIL reset_repress: pausa=%b dadoIn=%h, required pausa=%b dadoIn=%h",
                 pausa, dadoIn, exp_pausa(), m_dadoIn);
      end
    end
    ncomp++;
    if (dadoIn !== 32'h0000_1234) begin
      nerr++;
      $display("FAIL reset_repress_capture: dadoIn=%h, required 00001234", dadoIn);
    end
    botao = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_in_flow();
    lerIn = 1; chaves = 16'h00A5; botao = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ncomp++;
      if (pausa !== 1'b1) begin
        nerr++;
        $display("FAIL in_wait_pausa: pausa=%b, required 1", pausa);
      end
    end
    botao = 1;
    // edge 1 samples the press; capture lands 6 edges later
    for (int k = 1; k <= 7; k++) begin
      tick();
      ncomp++;
      if (k < 7 && (pausa !== 1'b1 || dadoIn !== 32'h0000_1234)) begin
        nerr++;
        $display("FAIL in_latency: edge %0d pausa=%b dadoIn=%h, required pausa=1 dadoIn=00001234",
                 k, pausa, dadoIn);
      end
      if (k == 7 && (pausa !== 1'b0 || dadoIn !== 32'h0000_00A5)) begin
        nerr++;
        $display("FAIL in_capture: pausa=%b dadoIn=%h, required pausa=0 dadoIn=000000a5", pausa, dadoIn);
      end
    end
    lerIn = 0; chaves = 16'hFFFF;
    tick();
    ncomp++;
    if (pausa !== 1'b0 || dadoIn !== 32'h0000_00A5) begin
      nerr++;
      $display("FAIL in_back_to_idle: pausa=%b dadoIn=%h, required pausa=0 dadoIn=000000a5", pausa, dadoIn);
    end
    botao = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_glitch();
    lerIn = 1; chaves = 16'h5A3C;
    tick(); tick();
    botao = 1;
    for (int i = 0; i < 3; i++) tick();
    botao = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ncomp++;
      if (pausa !== 1'b1 || dadoIn !== 32'h0000_00A5) begin
        nerr++;
        $display("FAIL glitch: pausa=%b dadoIn=%h, required pausa=1 dadoIn=000000a5", pausa, dadoIn);
      end
    end
    botao = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_lib) lerIn = 0;
    end
    ncomp++;
    if (dadoIn !== 32'h0000_5A3C || pausa !== 1'b0) begin
      nerr++;
      $display("FAIL glitch_then_press: dadoIn=%h pausa=%b, required dadoIn=00005a3c pausa=0", dadoIn, pausa);
    end
    botao = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_out();
    escreverOut = 1; dadoOut = 32'hDEAD_BEEF;
    tick();
    escreverOut = 0; dadoOut = $urandom;
    ncomp++;
    if (outValido !== 1'b1 || display !== 32'hDEAD_BEEF) begin
      nerr++;
      $display("FAIL out_update: outValido=%b display=%h, required 1 deadbeef", outValido, display);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      ncomp++;
      if (outValido !== 1'b0 || display !== 32'hDEAD_BEEF) begin
        nerr++;
        $display("FAIL out_hold: outValido=%b display=%h, required 0 deadbeef", outValido, display);
      end
    end
  endtask

  task automatic test_press_outside();
    lerIn = 0; botao = 1;
    for (int i = 0; i < 10; i++) tick();
    lerIn = 1; chaves = 16'hBEEF;
    for (int i = 0; i < 12; i++) begin
      tick();
      ncomp++;
      if (pausa !== 1'b1 || dadoIn !== 32'h0000_5A3C) begin
        nerr++;
        $display("FAIL press_outside_held: pausa=%b dadoIn=%h, required pausa=1 dadoIn=00005a3c", pausa, dadoIn);
      end
    end
    botao = 0;
    for (int i = 0; i < 8; i++) tick();
    botao = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_lib) lerIn = 0;
    end
    ncomp++;
    if (dadoIn !== 32'h0000_BEEF) begin
      nerr++;
      $display("FAIL press_outside_repress: dadoIn=%h, required 0000beef", dadoIn);
    end
    botao = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid_wait();
    lerIn = 1;
    for (int i = 0; i < 3; i++) tick();
    botao = 1;
    tick(); tick();
    rst_n = 0;
    tick();
    ncomp++;
    if (pausa !== 1'b0 || dadoIn !== 32'h0 || outValido !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_wait: pausa=%b dadoIn=%h outValido=%b, required 0 0 0", pausa, dadoIn, outValido);
    end
    rst_n = 1; lerIn = 0; botao = 0;
    tick();
    ncomp++;
    if (pausa !== 1'b0 || dadoIn !== 32'h0) begin
      nerr++;
      $display("FAIL reset_mid_wait_idle: pausa=%b dadoIn=%h, required 0 0", pausa, dadoIn);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (!lerIn && $urandom_range(0, 9) == 0) lerIn = 1;
      escreverOut = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) botao = ~botao;
      chaves = SW'($urandom);
      dadoOut = $urandom;
      tick();
      if (m_lib) lerIn = 0;
      ncomp++;
      if (pausa !== exp_pausa() || dadoIn !== m_dadoIn || display !== m_display || outValido !== m_ov) begin
        nerr++;
        $display("FAIL random cycle %0d: pausa=%b dadoIn=%h display=%h outValido=%b, required %b %h %h %b",
                 i, pausa, dadoIn, display, outValido, exp_pausa(), m_dadoIn, m_display, m_ov);
      end
    end
  endtask

  initial begin
    rst_n = 0; lerIn = 0; escreverOut = 0; dadoOut = '0; chaves = '0; botao = 0;
    test_reset();
    test_in_flow();
    test_glitch();
    test_out();
    test_press_outside();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
    $finish;
  end

endmodule
